// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide on magnitudes, UNROLL bits/cycle.
`timescale 1ns/1ps
module ex_muldiv #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             kill,
    output logic             stall,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] result
);
    localparam int DW = 2 * WIDTH;
    localparam int N  = WIDTH / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, next;

    logic [2:0]       f3_q;
    logic             sa_q, sb_q;
    logic [WIDTH-1:0] opnd;
    logic [DW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             sgn_a, sgn_b;
    logic             in_div, in_sa, in_sb;
    logic [WIDTH-1:0] in_ma, in_mb;
    logic             in_zero, in_ovf, in_special;
    logic [WIDTH-1:0] spec_val;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'b010: sgn_a = 1'b1;
            3'b011, 3'b101, 3'b111: begin
                sgn_a = 1'b0;
                sgn_b = 1'b0;
            end
        endcase
    end

    assign in_div = funct3[2];
    assign in_sa  = sgn_a & op_a[WIDTH-1];
    assign in_sb  = sgn_b & op_b[WIDTH-1];
    assign in_ma  = in_sa ? -op_a : op_a;
    assign in_mb  = in_sb ? -op_b : op_b;

    // Division corner cases bypass the iteration entirely.
    assign in_zero    = (op_b == '0);
    assign in_ovf     = ~funct3[0] & (op_a == MIN) & (op_b == ONES);
    assign in_special = in_div & (in_zero | in_ovf);

    always_comb begin
        if (in_zero)
            spec_val = funct3[1] ? op_a : ONES;
        else
            spec_val = funct3[1] ? '0 : MIN;
    end

    always_comb begin
        next   = state;
        stall  = 1'b0;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && !kill) begin
                    stall  = 1'b1;
                    accept = 1'b1;
                    next   = in_special ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (kill)
                    next = IDLE;
                else if (cnt == LAST)
                    next = FIX;
            end
            FIX: begin
                stall = 1'b1;
                next  = kill ? IDLE : DONE;
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
        stall = stall & rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next;
    end

    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [DW-1:0]    step;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   sum;

    always_comb begin
        step = acc;
        r_sh = '0;
        diff = '0;
        sum  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (f3_q[2]) begin
                r_sh = step[DW-1:WIDTH-1];
                diff = r_sh - {1'b0, opnd};
                if (!diff[WIDTH])
                    step = {diff[WIDTH-1:0], step[WIDTH-2:0], 1'b1};
                else
                    step = {r_sh[WIDTH-1:0], step[WIDTH-2:0], 1'b0};
            end else begin
                sum  = {1'b0, step[DW-1:WIDTH]}
                     + (step[0] ? {1'b0, opnd} : '0);
                step = {sum, step[WIDTH-1:1]};
            end
        end
    end

    logic             neg_q;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fix_val;

    assign neg_q = sa_q ^ sb_q;
    assign prod  = neg_q ? -acc : acc;
    assign quo   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem   = sa_q ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];

    always_comb begin
        fix_val = '0;
        unique case (f3_q)
            3'b000:                 fix_val = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[DW-1:WIDTH];
            3'b100, 3'b101:         fix_val = quo;
            3'b110, 3'b111:         fix_val = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                f3_q <= funct3;
                sa_q <= in_sa;
                sb_q <= in_sb;
                opnd <= in_div ? in_mb : in_ma;
                acc  <= {{WIDTH{1'b0}}, (in_div ? in_ma : in_mb)};
                cnt  <= '0;
                if (in_special)
                    result <= spec_val;
            end else if (state == CALC) begin
                acc <= step;
                cnt <= cnt + 1'b1;
            end else if (state == FIX && !kill) begin
                result <= fix_val;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors for ex_muldiv against an arithmetic model.
// A radix-2 and a radix-16 instance share clock and reset.
`timescale 1ns/1ps
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall, busy, resp_valid;
    logic [31:0] result;

    logic        req4 = 1'b0;
    logic        kill4 = 1'b0;
    logic [2:0]  f3_4 = '0;
    logic [31:0] a4 = '0;
    logic [31:0] b4 = '0;
    logic        stall4, busy4, resp4;
    logic [31:0] res4;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int nresp = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t expq[$];

    ex_muldiv #(.WIDTH(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .kill(kill), .stall(stall),
        .busy(busy), .resp_valid(resp_valid), .result(result)
    );

    ex_muldiv #(.WIDTH(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req4), .funct3(f3_4),
        .op_a(a4), .op_b(b4), .kill(kill4), .stall(stall4),
        .busy(busy4), .resp_valid(resp4), .result(res4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hffffffff;
                if (a == 32'h80000000 && b == 32'hffffffff) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hffffffff;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hffffffff) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // Scoreboard: every response is matched against the expected queue.
    initial begin
        logic [31:0] prev;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!resp_valid)
                    check("result_hold", result, prev);
                if (resp_valid) begin
                    nresp++;
                    last_res = result;
                    if (expq.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_resp: result %h at cycle %0d, none expected",
                                 result, cyc);
                    end else begin
                        e = expq.pop_front();
                        check("resp_result", result, e.res);
                        check("resp_cycle", cyc, e.at);
                    end
                end
            end
            prev = result;
        end
    end

    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit,
                         input string name);
        int sc, r0;
        bit sp, done;
        check({name, "_model"}, model(f, a, b), lit);
        sp = f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hffffffff));
        req_valid = 1'b1;
        funct3 = f;
        op_a = a;
        op_b = b;
        r0 = nresp;
        expq.push_back('{res: model(f, a, b), at: cyc + (sp ? 1 : 34)});
        sc = 0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall) sc++;
            else done = 1;
        end
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL %s_timeout: stall still high after 200 cycles", name);
        end
        check({name, "_stall_cycles"}, sc, sp ? 1 : 34);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({name, "_resp_count"}, nresp - r0, 1);
        check({name, "_result"}, last_res, lit);
    endtask

    task automatic do_op4(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit,
                          input string name);
        int t, sc;
        bit got;
        check({name, "_model"}, model(f, a, b), lit);
        req4 = 1'b1;
        f3_4 = f;
        a4 = a;
        b4 = b;
        t = cyc;
        sc = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (stall4) sc++;
            if (resp4) begin
                got = 1;
                check({name, "_result"}, res4, model(f, a, b));
                check({name, "_cycle"}, cyc, t + 10);
            end
        end
        if (!got) begin
            nvec++;
            nerr++;
            $display("FAIL %s_timeout: no resp_valid within 100 cycles", name);
        end
        check({name, "_stall_cycles"}, sc, 10);
        @(posedge clk);
        #1;
        req4 = 1'b0;
    endtask

    initial begin
        int r0;
        logic [31:0] held;
        #2;
        check("rst_stall", stall, 0);
        check("rst_busy", busy, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy4", busy4, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_op(3'd0, 32'd7, 32'hfffffffd, 32'hffffffeb, "mul_7_m3");
        do_op(3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe, "mulhu_max");
        do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
        do_op(3'd2, 32'hffffffff, 32'hffffffff, 32'hffffffff, "mulhsu_m1");
        do_op(3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, "div_m7_2");
        do_op(3'd6, 32'hfffffff9, 32'd2, 32'hffffffff, "rem_m7_2");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");
        do_op(3'd5, 32'd5, 32'd0, 32'hffffffff, "divu_by0");
        do_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        do_op(3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, "div_ovf");
        do_op(3'd6, 32'h80000000, 32'hffffffff, 32'd0, "rem_ovf");
        do_op(3'd0, 32'hfffffffe, 32'hfffffffd, 32'd6, "mul_m2_m3");
        do_op(3'd1, 32'hfffffffe, 32'd3, 32'hffffffff, "mulh_m2_3");
        do_op(3'd4, 32'd7, 32'hfffffffe, 32'hfffffffd, "div_7_m2");
        do_op(3'd6, 32'd7, 32'hfffffffe, 32'd1, "rem_7_m2");
        do_op(3'd3, 32'h80000000, 32'd2, 32'd1, "mulhu_hi");
        do_op(3'd4, 32'h80000000, 32'd1, 32'h80000000, "div_min_1");
        do_op(3'd4, 32'd5, 32'd0, 32'hffffffff, "div_by0");
        do_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0");

        // Kill together with a request in IDLE: nothing is accepted.
        req_valid = 1'b1;
        kill = 1'b1;
        funct3 = 3'd0;
        op_a = 32'd9;
        op_b = 32'd9;
        #1;
        check("idle_kill_stall", stall, 0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        req_valid = 1'b0;
        check("idle_kill_busy", busy, 0);

        // Kill an in-flight divide at T+10.
        r0 = nresp;
        held = result;
        req_valid = 1'b1;
        funct3 = 3'd4;
        op_a = 32'd1000;
        op_b = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        check("kill_busy_before", busy, 1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        req_valid = 1'b0;
        check("kill_busy_after", busy, 0);
        check("kill_stall_after", stall, 0);
        check("kill_result_held", result, held);
        repeat (40) @(posedge clk);
        #1;
        check("kill_no_resp", nresp - r0, 0);
        do_op(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_kill");

        // Reset in the middle of a divide, request still held.
        r0 = nresp;
        req_valid = 1'b1;
        funct3 = 3'd4;
        op_a = 32'h12345;
        op_b = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_busy", busy, 0);
        check("midrst_resp", resp_valid, 0);
        check("midrst_result", result, 0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_resp", nresp - r0, 0);
        do_op(3'd5, 32'hffffffff, 32'd1, 32'hffffffff, "divu_after_rst");

        do_op4(3'd0, 32'h12345678, 32'h10, 32'h23456780, "u4_mul");
        do_op4(3'd5, 32'd100, 32'd7, 32'd14, "u4_divu");
        do_op4(3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, "u4_div");
        do_op4(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "u4_mulh");
        do_op4(3'd6, 32'hfffffff9, 32'd2, 32'hffffffff, "u4_rem");

        check("pending_expectations", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
